e2tt_print_ctl: RTL
===================

Name: e2tt_print_ctl

Overview:
Sequences one EBCDIC character at a time through the e2tt converter and the console typewriter mechanism. It latches a character, waits out the converter latency and samples the tilt/rotate code and case flags. It then issues the required shift-up/shift-down, print, space or carrier-return operation, each with a fixed mechanical busy time. It tracks shift state and print column, and sits between the console channel data register and the typewriter magnet drivers.

Parameters:
XLAT_LAT, 3, cycles from o_data_reg change to valid i_tt_out/case flags (matches e2tt latency parameter)
PRINT_CYCLES, 8, cycles occupied by a print operation, strobe cycle included
SHIFT_CYCLES, 6, cycles occupied by a shift operation, strobe cycle included
SPACE_CYCLES, 4, cycles occupied by a space operation
CR_CYCLES, 20, cycles occupied by a carrier return
LINE_WIDTH, 8, printable columns per line; column counter width clog2(LINE_WIDTH+1)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  character available on i_data
o_ready  out  1  controller idle, character accepted when i_valid&&o_ready
i_data  in  8  EBCDIC character
o_data_reg  out  8  character driven to e2tt i_data_reg
i_tt_out  in  6  tilt/rotate code from e2tt
i_lower_case_character  in  1  from e2tt
i_upper_case_character  in  1  from e2tt
o_tt  out  6  tilt/rotate code held for magnets
o_print_strobe  out  1  one-cycle print pulse
o_shift_up  out  1  one-cycle pulse
o_shift_down  out  1  one-cycle pulse
o_space  out  1  one-cycle pulse
o_carrier_return  out  1  one-cycle pulse
o_case_upper  out  1  current shift state, 1=upper
o_column  out  clog2(LINE_WIDTH+1)  current print column, 0-based
o_drop  out  1  one-cycle pulse: character had no typewriter code

Behaviour:
- Reset: state IDLE; o_ready=1; o_data_reg=0x00; o_tt=0; all pulses 0; o_case_upper=0; o_column=0. Reset mid-operation aborts immediately, with no further pulses.
- States: IDLE, XLAT, DECIDE, SHIFT, PRINT, SPACE, CR. o_ready=1 only in IDLE.
- IDLE: on i_valid, latch i_data into o_data_reg and go to XLAT. The acceptance edge is cycle 0.
- XLAT: remain XLAT_LAT cycles (cycles 1..XLAT_LAT), then DECIDE. o_data_reg stays stable until return to IDLE.
- DECIDE (one cycle) samples the inputs; priority:
  - o_data_reg==0x15 (NL): CR.
  - column==LINE_WIDTH and character is printable or 0x40: auto-CR; after CR, return to DECIDE (inputs still valid, since o_data_reg is unchanged).
  - 0x40 (SP): SPACE. Case-neutral.
  - upper=1, lower=0, o_case_upper=0: SHIFT (up).
  - lower=1, upper=0, o_case_upper=1: SHIFT (down).
  - upper=1 or lower=1 otherwise (both set = case-neutral): latch o_tt<=i_tt_out, go to PRINT.
  - both flags 0: pulse o_drop in DECIDE cycle, go to IDLE.
- Each action state asserts its pulse in its first cycle only and occupies its *_CYCLES cycles total.
- SHIFT: toggles o_case_upper at the pulse, then returns to DECIDE, which re-evaluates and now selects PRINT.
- PRINT: o_tt latched at DECIDE is held for the whole state; column += 1 at the strobe; then IDLE.
- SPACE: column += 1, then IDLE.
- CR: column <= 0, shift state unchanged, then IDLE (or DECIDE for auto-CR).
- Column never exceeds LINE_WIDTH. At most one pulse is asserted in any cycle.
- i_valid while busy is ignored; no queueing.

Test Plan:
- Reset, send 0xF0 (case-neutral) at cycle 0 -> DECIDE at cycle 4; o_print_strobe at cycle 5 with o_tt = e2tt code; no shift; o_ready high again at cycle 13; o_column=1.
- From reset, send 0xC1 ('A') -> o_shift_up at cycle 5; o_case_upper=1 from cycle 6; DECIDE at cycle 11; o_print_strobe at cycle 12; o_ready at cycle 20.
- After 'A', send 0x81 ('a') -> o_shift_down then print; o_case_upper=0; next 0x81 prints with no shift pulse.
- Send 0x40 -> o_space only, column increments, o_case_upper unchanged; send 0x15 -> o_carrier_return, column=0, busy CR_CYCLES.
- Print 8 chars, then a 9th 0xF0 -> auto o_carrier_return, then o_print_strobe; final column=1.
- Send an unmapped byte (e.g. 0x00, both flags 0) -> o_drop pulse at cycle 4, ready at cycle 5. Assert i_reset during SHIFT -> all outputs at reset values next cycle, no print strobe.

Source files
------------

// File: rtl/e2tt_print_ctl.sv
// Console typewriter print controller.
// Takes one EBCDIC character at a time and presents it to the e2tt converter.
// After the converter latency it reads back the tilt/rotate code and the case flags.
// It then sequences the shift, print, space and carrier-return magnets, each with a
// fixed mechanical busy time, while tracking shift state and print column.
module e2tt_print_ctl #(
  parameter int XLAT_LAT     = 3,
  parameter int PRINT_CYCLES = 8,
  parameter int SHIFT_CYCLES = 6,
  parameter int SPACE_CYCLES = 4,
  parameter int CR_CYCLES    = 20,
  parameter int LINE_WIDTH   = 8
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [7:0]                        i_data,
  output logic [7:0]                        o_data_reg,
  input  logic [5:0]                        i_tt_out,
  input  logic                              i_lower_case_character,
  input  logic                              i_upper_case_character,
  output logic [5:0]                        o_tt,
  output logic                              o_print_strobe,
  output logic                              o_shift_up,
  output logic                              o_shift_down,
  output logic                              o_space,
  output logic                              o_carrier_return,
  output logic                              o_case_upper,
  output logic [$clog2(LINE_WIDTH+1)-1:0]   o_column,
  output logic                              o_drop
);

  localparam int COL_W = $clog2(LINE_WIDTH + 1);
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_XLAT, S_DECIDE, S_SHIFT, S_PRINT, S_SPACE, S_CR
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_data;
  logic [5:0]       r_tt;
  logic             r_case_upper;
  logic [COL_W-1:0] r_col;
  logic             r_auto;
  logic             r_print_strobe;
  logic             r_shift_up;
  logic             r_shift_down;
  logic             r_space;
  logic             r_cr;

  logic w_nl;
  logic w_sp;
  logic w_up_only;
  logic w_lo_only;
  logic w_any_case;
  logic w_full;
  logic w_auto_cr;
  logic w_drop;
  logic w_cnt_done;

  // Character classification used by the DECIDE cycle; the flags come straight from e2tt.
  always_comb begin
    w_nl       = (r_data == 8'h15);
    w_sp       = (r_data == 8'h40);
    w_up_only  = i_upper_case_character && !i_lower_case_character;
    w_lo_only  = i_lower_case_character && !i_upper_case_character;
    w_any_case = i_upper_case_character || i_lower_case_character;
    w_full     = (r_col == COL_W'(LINE_WIDTH));
    w_auto_cr  = w_full && (w_any_case || w_sp);
    // Drop is the lowest-priority DECIDE outcome and must show in the DECIDE cycle itself.
    w_drop     = (r_state == S_DECIDE) && !w_nl && !w_auto_cr && !w_sp && !w_any_case;
    w_cnt_done = (r_cnt == '0);
  end

  // Main sequencer: state, busy counter, latched character/code, shift state, column and pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_data         <= 8'h00;
      r_tt           <= 6'd0;
      r_case_upper   <= 1'b0;
      r_col          <= '0;
      r_auto         <= 1'b0;
      r_print_strobe <= 1'b0;
      r_shift_up     <= 1'b0;
      r_shift_down   <= 1'b0;
      r_space        <= 1'b0;
      r_cr           <= 1'b0;
    end else begin
      // Magnet pulses last exactly one cycle: the first cycle of their action state.
      r_print_strobe <= 1'b0;
      r_shift_up     <= 1'b0;
      r_shift_down   <= 1'b0;
      r_space        <= 1'b0;
      r_cr           <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_data  <= i_data;
            r_cnt   <= CNT_W'(XLAT_LAT - 1);
            r_state <= S_XLAT;
          end
        end

        S_XLAT: begin
          if (w_cnt_done) r_state <= S_DECIDE;
          else            r_cnt   <= r_cnt - 1'b1;
        end

        S_DECIDE: begin
          if (w_nl) begin
            r_cr    <= 1'b1;
            r_auto  <= 1'b0;
            r_cnt   <= CNT_W'(CR_CYCLES - 1);
            r_state <= S_CR;
          end else if (w_auto_cr) begin
            // Line is full: return the carrier first, then re-decide the same character.
            r_cr    <= 1'b1;
            r_auto  <= 1'b1;
            r_cnt   <= CNT_W'(CR_CYCLES - 1);
            r_state <= S_CR;
          end else if (w_sp) begin
            r_space <= 1'b1;
            r_cnt   <= CNT_W'(SPACE_CYCLES - 1);
            r_state <= S_SPACE;
          end else if (w_up_only && !r_case_upper) begin
            r_shift_up <= 1'b1;
            r_cnt      <= CNT_W'(SHIFT_CYCLES - 1);
            r_state    <= S_SHIFT;
          end else if (w_lo_only && r_case_upper) begin
            r_shift_down <= 1'b1;
            r_cnt        <= CNT_W'(SHIFT_CYCLES - 1);
            r_state      <= S_SHIFT;
          end else if (w_any_case) begin
            r_tt           <= i_tt_out;
            r_print_strobe <= 1'b1;
            r_cnt          <= CNT_W'(PRINT_CYCLES - 1);
            r_state        <= S_PRINT;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_SHIFT: begin
          if (r_shift_up || r_shift_down) r_case_upper <= ~r_case_upper;
          if (w_cnt_done) r_state <= S_DECIDE;
          else            r_cnt   <= r_cnt - 1'b1;
        end

        S_PRINT: begin
          if (r_print_strobe && (r_col < COL_W'(LINE_WIDTH))) r_col <= r_col + 1'b1;
          if (w_cnt_done) r_state <= S_IDLE;
          else            r_cnt   <= r_cnt - 1'b1;
        end

        S_SPACE: begin
          if (r_space && (r_col < COL_W'(LINE_WIDTH))) r_col <= r_col + 1'b1;
          if (w_cnt_done) r_state <= S_IDLE;
          else            r_cnt   <= r_cnt - 1'b1;
        end

        S_CR: begin
          if (r_cr) r_col <= '0;
          if (w_cnt_done) begin
            r_auto  <= 1'b0;
            r_state <= r_auto ? S_DECIDE : S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready          = (r_state == S_IDLE);
  assign o_data_reg       = r_data;
  assign o_tt             = r_tt;
  assign o_print_strobe   = r_print_strobe;
  assign o_shift_up       = r_shift_up;
  assign o_shift_down     = r_shift_down;
  assign o_space          = r_space;
  assign o_carrier_return = r_cr;
  assign o_case_upper     = r_case_upper;
  assign o_column         = r_col;
  assign o_drop           = w_drop;

endmodule
